// File: rtl/ps2_game_ctrl.sv
// ps2_game_ctrl
// Keyboard command controller for the Game of Life core.
// Takes the decoded PS/2 byte stream, strips the make/break/extended
// prefixes, and turns key presses into cursor moves, run/pause and speed
// changes. It also produces TOGGLE/STEP/CLEAR commands, which are offered
// to the grid engine over a valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   ps2_byte   scan-code byte, stable while ps2_state is high
//   ps2_state  byte-ready level; each rising edge delivers one byte
//   cur_x/y    edit-cursor position
//   running    1 = generations advance automatically
//   speed      generation-rate select, 0 slowest .. 7 fastest
//   cmd_valid  command pending to the grid engine
//   cmd_op     01 TOGGLE, 10 STEP, 11 CLEAR
//   cmd_x/y    TOGGLE target, frozen at issue
//   cmd_ready  grid engine accepts when high together with cmd_valid
module ps2_game_ctrl #(
    parameter int GRID_W = 32,
    parameter int GRID_H = 32,
    parameter int XW     = 5,
    parameter int YW     = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    ps2_byte,
    input  logic          ps2_state,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic          running,
    output logic [2:0]    speed,
    output logic          cmd_valid,
    output logic [1:0]    cmd_op,
    output logic [XW-1:0] cmd_x,
    output logic [YW-1:0] cmd_y,
    input  logic          cmd_ready
);

    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_UP    = 8'h75;
    localparam logic [7:0] CODE_DOWN  = 8'h72;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;
    localparam logic [7:0] CODE_SPACE = 8'h29;
    localparam logic [7:0] CODE_ENTER = 8'h5A;
    localparam logic [7:0] CODE_N     = 8'h31;
    localparam logic [7:0] CODE_C     = 8'h21;
    localparam logic [7:0] CODE_1     = 8'h16;
    localparam logic [7:0] CODE_2     = 8'h1E;

    localparam logic [1:0] OP_TOGGLE = 2'b01;
    localparam logic [1:0] OP_STEP   = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

    logic [2:0] samp;
    logic       strobe;
    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       is_make;
    logic       is_ext;

    logic key_up, key_down, key_left, key_right;
    logic key_toggle, key_enter, key_step, key_clear, key_slower, key_faster;
    logic       issue_req;
    logic [1:0] issue_op;

    // The byte-ready level is sampled into a shift register. A rising edge
    // of the level produces exactly one strobe, however long it stays high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) samp <= 3'b000;
        else     samp <= {samp[1:0], ps2_state};
    end

    assign strobe = samp[1] & ~samp[2];

    // Prefix tracking. The action registers act on ps2_byte directly at the
    // strobe edge, because the receiver holds the byte stable while the
    // level is high.
    always_comb begin
        state_nxt = state;
        is_make   = 1'b0;
        is_ext    = 1'b0;
        if (strobe) begin
            case (state)
                ST_IDLE: begin
                    if (ps2_byte == CODE_BRK)      state_nxt = ST_BRK;
                    else if (ps2_byte == CODE_EXT) state_nxt = ST_EXT;
                    else                           is_make   = 1'b1;
                end
                ST_EXT: begin
                    if (ps2_byte == CODE_BRK) begin
                        state_nxt = ST_EXT_BRK;
                    end else begin
                        is_make   = 1'b1;
                        is_ext    = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Arrow keys exist only as extended codes. Every other key exists only
    // as a plain code, so an E0 prefix in front of it means "no action".
    assign key_up     = is_make &  is_ext & (ps2_byte == CODE_UP);
    assign key_down   = is_make &  is_ext & (ps2_byte == CODE_DOWN);
    assign key_left   = is_make &  is_ext & (ps2_byte == CODE_LEFT);
    assign key_right  = is_make &  is_ext & (ps2_byte == CODE_RIGHT);
    assign key_toggle = is_make & ~is_ext & (ps2_byte == CODE_SPACE);
    assign key_enter  = is_make & ~is_ext & (ps2_byte == CODE_ENTER);
    assign key_step   = is_make & ~is_ext & (ps2_byte == CODE_N);
    assign key_clear  = is_make & ~is_ext & (ps2_byte == CODE_C);
    assign key_slower = is_make & ~is_ext & (ps2_byte == CODE_1);
    assign key_faster = is_make & ~is_ext & (ps2_byte == CODE_2);

    // STEP only makes sense while paused, so it is not requested while running.
    always_comb begin
        issue_req = 1'b0;
        issue_op  = 2'b00;
        if (key_toggle) begin
            issue_req = 1'b1;
            issue_op  = OP_TOGGLE;
        end else if (key_step && !running) begin
            issue_req = 1'b1;
            issue_op  = OP_STEP;
        end else if (key_clear) begin
            issue_req = 1'b1;
            issue_op  = OP_CLEAR;
        end
    end

    // Cursor movement wraps around the grid edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_x <= '0;
            cur_y <= '0;
        end else begin
            if (key_up)
                cur_y <= (cur_y == '0) ? Y_MAX : cur_y - YW'(1);
            else if (key_down)
                cur_y <= (cur_y == Y_MAX) ? '0 : cur_y + YW'(1);
            if (key_left)
                cur_x <= (cur_x == '0) ? X_MAX : cur_x - XW'(1);
            else if (key_right)
                cur_x <= (cur_x == X_MAX) ? '0 : cur_x + XW'(1);
        end
    end

    // CLEAR always pauses, even when its command is dropped because
    // another command is still pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            speed   <= 3'd3;
        end else begin
            if (key_enter)      running <= ~running;
            else if (key_clear) running <= 1'b0;
            if (key_slower && speed != 3'd0)      speed <= speed - 3'd1;
            else if (key_faster && speed != 3'd7) speed <= speed + 3'd1;
        end
    end

    // Command register. A pending command blocks new ones until it is
    // accepted, and its target is snapshotted at issue time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd_op    <= 2'b00;
            cmd_x     <= '0;
            cmd_y     <= '0;
        end else if (cmd_valid) begin
            if (cmd_ready) cmd_valid <= 1'b0;
        end else if (issue_req) begin
            cmd_valid <= 1'b1;
            cmd_op    <= issue_op;
            cmd_x     <= cur_x;
            cmd_y     <= cur_y;
        end
    end

endmodule

// File: tb/tb_ps2_game_ctrl.sv
// Testbench for ps2_game_ctrl.
// A vector table is followed by hand-written corner sequences, and then a
// randomized byte stream that is compared against a key-level reference model.
module tb_ps2_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] ps2_byte = 8'h00;
    logic       ps2_state = 1'b0;
    logic [4:0] cur_x, cur_y, cmd_x, cmd_y;
    logic       running, cmd_valid, cmd_ready = 1'b0;
    logic [2:0] speed;
    logic [1:0] cmd_op;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [7:0] b;
        bit         rdy;
        int         x, y, run, spd, vld, op;
    } vec_t;

    vec_t vecs[$];

    // Reference model state.
    int m_x, m_y, m_run, m_spd, m_vld, m_op, m_cx, m_cy;
    bit m_ext, m_brk;

    ps2_game_ctrl dut (
        .clk(clk), .rst(rst), .ps2_byte(ps2_byte), .ps2_state(ps2_state),
        .cur_x(cur_x), .cur_y(cur_y), .running(running), .speed(speed),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .cmd_ready(cmd_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total_cnt++;
        if (actual == expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Raises ps2_state with the byte and returns just after the edge that
    // applies the action (third edge after the rise).
    task automatic applyStimulus(input logic [7:0] b, input bit r);
        @(negedge clk);
        ps2_byte  = b;
        cmd_ready = r;
        ps2_state = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic finishByte();
        @(negedge clk);
        ps2_state = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b, input bit r);
        applyStimulus(b, r);
        finishByte();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        ps2_state = 1'b0;
        cmd_ready = 1'b0;
        ps2_byte  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " cur_x"}, int'(cur_x), 0);
        checkOutput({tag, " cur_y"}, int'(cur_y), 0);
        checkOutput({tag, " running"}, int'(running), 0);
        checkOutput({tag, " speed"}, int'(speed), 3);
        checkOutput({tag, " cmd_valid"}, int'(cmd_valid), 0);
        checkOutput({tag, " cmd_op"}, int'(cmd_op), 0);
        checkOutput({tag, " cmd_x"}, int'(cmd_x), 0);
        checkOutput({tag, " cmd_y"}, int'(cmd_y), 0);
    endtask

    function automatic void addVec(logic [7:0] b, bit r, int x, int y, int run, int spd, int vld, int op);
        vec_t v;
        v.b = b; v.rdy = r; v.x = x; v.y = y; v.run = run; v.spd = spd; v.vld = vld; v.op = op;
        vecs.push_back(v);
    endfunction

    function automatic void modelIssue(int op);
        if (m_vld == 0) begin
            m_vld = 1; m_op = op; m_cx = m_x; m_cy = m_y;
        end
    endfunction

    // Key-level reference: prefixes are tracked as two flags, and each
    // completed make code is applied with plain modular arithmetic.
    function automatic void modelByte(logic [7:0] b);
        if (m_brk) begin
            m_brk = 0;
            m_ext = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0 && !m_ext) begin
            m_ext = 1;
        end else begin
            if (m_ext) begin
                case (b)
                    8'h75: m_y = (m_y + 31) % 32;
                    8'h72: m_y = (m_y + 1) % 32;
                    8'h6B: m_x = (m_x + 31) % 32;
                    8'h74: m_x = (m_x + 1) % 32;
                    default: ;
                endcase
            end else begin
                case (b)
                    8'h29: modelIssue(1);
                    8'h5A: m_run = 1 - m_run;
                    8'h31: if (m_run == 0) modelIssue(2);
                    8'h21: begin modelIssue(3); m_run = 0; end
                    8'h16: if (m_spd > 0) m_spd--;
                    8'h1E: if (m_spd < 7) m_spd++;
                    default: ;
                endcase
            end
            m_ext = 0;
        end
    endfunction

    initial begin
        logic [7:0] pool [13];
        logic [7:0] b;
        bit r;
        int k;

        doReset();
        checkResetValues("reset");

        // Latency: the action lands on the third edge, and a long high level
        // still counts as a single byte.
        @(negedge clk);
        ps2_byte = 8'h5A;
        ps2_state = 1'b1;
        repeat (2) @(posedge clk);
        #1 checkOutput("latency edge2 running", int'(running), 0);
        @(posedge clk);
        #1 checkOutput("latency edge3 running", int'(running), 1);
        repeat (10) @(posedge clk);
        #1 checkOutput("held-high single strobe", int'(running), 1);
        finishByte();
        applyStimulus(8'h5A, 0);
        checkOutput("second enter running", int'(running), 0);
        finishByte();

        addVec(8'h5A,0, 0,0,1,3,0,0);
        addVec(8'h5A,0, 0,0,0,3,0,0);
        addVec(8'hE0,0, 0,0,0,3,0,0);
        addVec(8'h6B,0, 31,0,0,3,0,0);
        addVec(8'hE0,0, 31,0,0,3,0,0);
        addVec(8'hF0,0, 31,0,0,3,0,0);
        addVec(8'h6B,0, 31,0,0,3,0,0);
        addVec(8'hE0,0, 31,0,0,3,0,0);
        addVec(8'h75,0, 31,31,0,3,0,0);
        addVec(8'hE0,0, 31,31,0,3,0,0);
        addVec(8'h72,0, 31,0,0,3,0,0);
        addVec(8'hE0,0, 31,0,0,3,0,0);
        addVec(8'h74,0, 0,0,0,3,0,0);
        addVec(8'h75,0, 0,0,0,3,0,0);
        addVec(8'h1E,0, 0,0,0,4,0,0);
        addVec(8'h1E,0, 0,0,0,5,0,0);
        addVec(8'h1E,0, 0,0,0,6,0,0);
        addVec(8'h1E,0, 0,0,0,7,0,0);
        addVec(8'h1E,0, 0,0,0,7,0,0);
        addVec(8'h16,0, 0,0,0,6,0,0);
        addVec(8'h16,0, 0,0,0,5,0,0);
        addVec(8'h16,0, 0,0,0,4,0,0);
        addVec(8'h16,0, 0,0,0,3,0,0);
        addVec(8'h16,0, 0,0,0,2,0,0);
        addVec(8'h16,0, 0,0,0,1,0,0);
        addVec(8'h16,0, 0,0,0,0,0,0);
        addVec(8'h16,0, 0,0,0,0,0,0);
        addVec(8'h5A,0, 0,0,1,0,0,0);
        addVec(8'h31,1, 0,0,1,0,0,0);
        addVec(8'h21,1, 0,0,0,0,1,3);
        addVec(8'h31,1, 0,0,0,0,1,2);
        addVec(8'h29,1, 0,0,0,0,1,1);
        addVec(8'hF0,1, 0,0,0,0,0,0);
        addVec(8'h29,1, 0,0,0,0,0,0);
        addVec(8'hE0,1, 0,0,0,0,0,0);
        addVec(8'h29,1, 0,0,0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].b, vecs[i].rdy);
            checkOutput($sformatf("vec%0d cur_x", i), int'(cur_x), vecs[i].x);
            checkOutput($sformatf("vec%0d cur_y", i), int'(cur_y), vecs[i].y);
            checkOutput($sformatf("vec%0d running", i), int'(running), vecs[i].run);
            checkOutput($sformatf("vec%0d speed", i), int'(speed), vecs[i].spd);
            checkOutput($sformatf("vec%0d cmd_valid", i), int'(cmd_valid), vecs[i].vld);
            if (vecs[i].vld != 0)
                checkOutput($sformatf("vec%0d cmd_op", i), int'(cmd_op), vecs[i].op);
            finishByte();
        end

        // Pending TOGGLE is held, frozen and blocks new commands.
        doReset();
        repeat (4) begin sendByte(8'hE0, 0); sendByte(8'h74, 0); end
        repeat (7) begin sendByte(8'hE0, 0); sendByte(8'h72, 0); end
        applyStimulus(8'h29, 0);
        checkOutput("toggle valid", int'(cmd_valid), 1);
        checkOutput("toggle op", int'(cmd_op), 1);
        checkOutput("toggle x", int'(cmd_x), 4);
        checkOutput("toggle y", int'(cmd_y), 7);
        finishByte();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 checkOutput($sformatf("hold%0d valid", i), int'(cmd_valid), 1);
            checkOutput($sformatf("hold%0d cmd_x", i), int'(cmd_x), 4);
        end
        sendByte(8'hE0, 0);
        applyStimulus(8'h74, 0);
        checkOutput("move while pending cur_x", int'(cur_x), 5);
        checkOutput("move while pending cmd_x", int'(cmd_x), 4);
        finishByte();
        applyStimulus(8'h31, 0);
        checkOutput("step dropped op", int'(cmd_op), 1);
        finishByte();
        sendByte(8'h5A, 0);
        applyStimulus(8'h21, 0);
        checkOutput("dropped clear running", int'(running), 0);
        checkOutput("dropped clear op", int'(cmd_op), 1);
        finishByte();
        @(negedge clk);
        cmd_ready = 1'b1;
        @(posedge clk);
        #1 checkOutput("accept drops valid", int'(cmd_valid), 0);
        @(negedge clk);
        cmd_ready = 1'b0;
        sendByte(8'h5A, 0);
        applyStimulus(8'h31, 0);
        checkOutput("step while running", int'(cmd_valid), 0);
        finishByte();
        applyStimulus(8'h21, 1);
        checkOutput("zero-wait valid", int'(cmd_valid), 1);
        checkOutput("zero-wait op", int'(cmd_op), 3);
        @(posedge clk);
        #1 checkOutput("zero-wait one cycle", int'(cmd_valid), 0);
        finishByte();

        // Randomized stream against the reference model.
        doReset();
        m_x = 0; m_y = 0; m_run = 0; m_spd = 3; m_vld = 0; m_op = 0;
        m_cx = 0; m_cy = 0; m_ext = 0; m_brk = 0;
        pool = '{8'hE0, 8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
                 8'h29, 8'h5A, 8'h31, 8'h21, 8'h16, 8'h1E};
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 13);
            if (k == 13) b = 8'($urandom);
            else         b = pool[k];
            r = 1'($urandom_range(0, 1));
            if (m_vld != 0 && r) m_vld = 0;
            applyStimulus(b, r);
            modelByte(b);
            checkOutput($sformatf("rnd%0d cur_x", i), int'(cur_x), m_x);
            checkOutput($sformatf("rnd%0d cur_y", i), int'(cur_y), m_y);
            checkOutput($sformatf("rnd%0d running", i), int'(running), m_run);
            checkOutput($sformatf("rnd%0d speed", i), int'(speed), m_spd);
            checkOutput($sformatf("rnd%0d cmd_valid", i), int'(cmd_valid), m_vld);
            if (m_vld != 0) begin
                checkOutput($sformatf("rnd%0d cmd_op", i), int'(cmd_op), m_op);
                checkOutput($sformatf("rnd%0d cmd_x", i), int'(cmd_x), m_cx);
                checkOutput($sformatf("rnd%0d cmd_y", i), int'(cmd_y), m_cy);
            end
            finishByte();
            if (m_vld != 0 && r) m_vld = 0;
            checkOutput($sformatf("rnd%0d post valid", i), int'(cmd_valid), m_vld);
        end

        // Asynchronous reset in the middle of an extended prefix with a command pending.
        doReset();
        sendByte(8'hE0, 0);
        sendByte(8'h74, 0);
        sendByte(8'h29, 0);
        sendByte(8'hE0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 checkResetValues("async reset");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'h75, 0);
        checkOutput("post-reset 75 cur_y", int'(cur_y), 0);
        checkOutput("post-reset 75 cur_x", int'(cur_x), 0);
        finishByte();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
